// File: rtl/a_res_sched_if.sv
// a_res_sched_if: issue/writeback bundle between an A-register issuer and
// the a_res_sched result scheduler.
// Optional feature: A_SCHED_FLUSH_EN adds the i_flush request line.
interface a_res_sched_if #(
    parameter int NUM_AREG = 8,
    parameter int DELAY_W  = 4,
    parameter int SRC_W    = 4
);
    localparam int AW = $clog2(NUM_AREG);

    logic                i_issue;
    logic                i_dest_en;
    logic [AW-1:0]       i_dest;
    logic [DELAY_W-1:0]  i_delay;
    logic [SRC_W-1:0]    i_src;
    logic                i_j_en;
    logic                i_k_en;
    logic [AW-1:0]       i_j;
    logic [AW-1:0]       i_k;
`ifdef A_SCHED_FLUSH_EN
    logic                i_flush;
`endif
    logic                o_hold;
    logic                o_wr_en;
    logic [AW-1:0]       o_wr_addr;
    logic [SRC_W-1:0]    o_wr_src;
    logic [NUM_AREG-1:0] o_busy;

`ifdef A_SCHED_FLUSH_EN
    modport master (
        output i_issue, i_dest_en, i_dest, i_delay, i_src,
        output i_j_en, i_k_en, i_j, i_k, i_flush,
        input  o_hold, o_wr_en, o_wr_addr, o_wr_src, o_busy
    );
    modport slave (
        input  i_issue, i_dest_en, i_dest, i_delay, i_src,
        input  i_j_en, i_k_en, i_j, i_k, i_flush,
        output o_hold, o_wr_en, o_wr_addr, o_wr_src, o_busy
    );
`else
    modport master (
        output i_issue, i_dest_en, i_dest, i_delay, i_src,
        output i_j_en, i_k_en, i_j, i_k,
        input  o_hold, o_wr_en, o_wr_addr, o_wr_src, o_busy
    );
    modport slave (
        input  i_issue, i_dest_en, i_dest, i_delay, i_src,
        input  i_j_en, i_k_en, i_j, i_k,
        output o_hold, o_wr_en, o_wr_addr, o_wr_src, o_busy
    );
`endif
endinterface

// File: rtl/a_res_sched.sv
// a_res_sched: A-register reservation and result-bus scheduler.
// A timing-slot table tracks pending writes; slot k holds the write that
// lands k cycles from now, so slot 0 drives the write port this cycle.
// Issue is held on result-bus collision, WAW and RAW hazards.
// Optional feature: define A_SCHED_FLUSH_EN to add the synchronous i_flush.
module a_res_sched #(
    parameter int NUM_AREG = 8,
    parameter int DELAY_W  = 4,
    parameter int SRC_W    = 4
) (
    input logic          clk,
    input logic          rst_n,
    a_res_sched_if.slave bus
);
    localparam int          AW    = $clog2(NUM_AREG);
    localparam int unsigned DEPTH = (1 << DELAY_W) - 1;

    typedef struct packed {
        logic             valid;
        logic [AW-1:0]    addr;
        logic [SRC_W-1:0] src;
    } slot_t;

    slot_t [DEPTH-1:0]   slot_q, slot_d;
    logic [NUM_AREG-1:0] busy_q, busy_d;

    logic reserve;
    logic collide;
    logic retire_hit;
    logic waw;
    logic raw;
    logic flush;
    logic hold;
    logic accept;

`ifdef A_SCHED_FLUSH_EN
    assign flush = bus.i_flush;
`else
    assign flush = 1'b0;
`endif

    // Hazard detection: bus collision, WAW (unless the old write retires now), RAW.
    always_comb begin
        reserve = bus.i_dest_en && (bus.i_delay != '0);
        collide = 1'b0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (32'(bus.i_delay) == k && slot_q[k[DELAY_W-1:0]].valid) begin
                collide = 1'b1;
            end
        end
        retire_hit = slot_q[0].valid && (slot_q[0].addr == bus.i_dest);
        waw        = reserve && busy_q[bus.i_dest] && !retire_hit;
        raw        = (bus.i_j_en && busy_q[bus.i_j]) || (bus.i_k_en && busy_q[bus.i_k]);
        hold       = flush || (bus.i_issue && ((reserve && collide) || waw || raw));
        accept     = bus.i_issue && !hold;
    end

    assign bus.o_hold    = hold;
    assign bus.o_wr_en   = slot_q[0].valid && !flush;
    assign bus.o_wr_addr = slot_q[0].addr;
    assign bus.o_wr_src  = slot_q[0].src;
    assign bus.o_busy    = busy_q;

    // Next state: shift slots toward 0, retire slot 0, then insert the accepted write.
    always_comb begin
        slot_d = '0;
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            slot_d[k[DELAY_W-1:0]] = slot_q[k[DELAY_W-1:0] + 1'b1];
        end
        busy_d = busy_q;
        if (slot_q[0].valid) begin
            busy_d[slot_q[0].addr] = 1'b0;
        end
        // Insertion follows retirement so a same-register re-reservation keeps busy set.
        if (accept && reserve) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (32'(bus.i_delay) == k + 1) begin
                    slot_d[k[DELAY_W-1:0]].valid = 1'b1;
                    slot_d[k[DELAY_W-1:0]].addr  = bus.i_dest;
                    slot_d[k[DELAY_W-1:0]].src   = bus.i_src;
                end
            end
            busy_d[bus.i_dest] = 1'b1;
        end
        if (flush) begin
            slot_d = '0;
            busy_d = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            busy_q <= '0;
        end else begin
            slot_q <= slot_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_a_res_sched.sv
// tb_a_res_sched: directed table-driven checks of a_res_sched plus
// hand-written reset and flush sequences.
module tb_a_res_sched;
    localparam int NUM_AREG = 8;
    localparam int DELAY_W  = 4;
    localparam int SRC_W    = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    a_res_sched_if #(.NUM_AREG(NUM_AREG), .DELAY_W(DELAY_W), .SRC_W(SRC_W)) bus ();

    a_res_sched #(.NUM_AREG(NUM_AREG), .DELAY_W(DELAY_W), .SRC_W(SRC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       iss;
        logic       den;
        logic [2:0] dst;
        logic [3:0] dly;
        logic [3:0] src;
        logic       jen;
        logic [2:0] j;
        logic       ken;
        logic [2:0] k;
        logic       h;
        logic       we;
        logic [2:0] wa;
        logic [3:0] ws;
        logic [7:0] bz;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic iss, input logic den, input logic [2:0] dst,
                                input logic [3:0] dly, input logic [3:0] src,
                                input logic jen, input logic [2:0] j,
                                input logic ken, input logic [2:0] k,
                                input logic h, input logic we, input logic [2:0] wa,
                                input logic [3:0] ws, input logic [7:0] bz);
        vec_t v;
        v.iss = iss; v.den = den; v.dst = dst; v.dly = dly; v.src = src;
        v.jen = jen; v.j = j; v.ken = ken; v.k = k;
        v.h = h; v.we = we; v.wa = wa; v.ws = ws; v.bz = bz;
        return v;
    endfunction

    function automatic vec_t v_iss(input logic [2:0] dst, input logic [3:0] dly,
                                   input logic [3:0] src, input logic h, input logic we,
                                   input logic [2:0] wa, input logic [3:0] ws,
                                   input logic [7:0] bz);
        return mk(1, 1, dst, dly, src, 0, 0, 0, 0, h, we, wa, ws, bz);
    endfunction

    function automatic vec_t v_idle(input logic we, input logic [2:0] wa,
                                    input logic [3:0] ws, input logic [7:0] bz);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, we, wa, ws, bz);
    endfunction

    task automatic drive(input vec_t v);
        bus.i_issue   = v.iss;
        bus.i_dest_en = v.den;
        bus.i_dest    = v.dst;
        bus.i_delay   = v.dly;
        bus.i_src     = v.src;
        bus.i_j_en    = v.jen;
        bus.i_j       = v.j;
        bus.i_k_en    = v.ken;
        bus.i_k       = v.k;
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        // Rows are consecutive cycles; each scenario drains before the next starts.
        // Delay 5 write to r3, with collision, RAW on Ak, no-reservation issue, WAW.
        tv.push_back(v_iss(3, 5, 4, 0, 0, 0, 0, 8'h00));
        tv.push_back(v_iss(0, 4, 1, 1, 0, 0, 0, 8'h08));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 8'h08));
        tv.push_back(mk(1, 1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8'h08));
        tv.push_back(v_iss(3, 2, 2, 1, 0, 0, 0, 8'h08));
        tv.push_back(v_idle(1, 3, 4, 8'h08));
        tv.push_back(v_idle(0, 0, 0, 8'h00));
        // Result-bus collision, then re-issue one cycle later.
        tv.push_back(v_iss(1, 4, 5, 0, 0, 0, 0, 8'h00));
        tv.push_back(v_iss(2, 3, 6, 1, 0, 0, 0, 8'h02));
        tv.push_back(v_iss(2, 3, 6, 0, 0, 0, 0, 8'h02));
        tv.push_back(v_idle(0, 0, 0, 8'h06));
        tv.push_back(v_idle(1, 1, 5, 8'h06));
        tv.push_back(v_idle(1, 2, 6, 8'h04));
        tv.push_back(v_idle(0, 0, 0, 8'h00));
        // RAW on Aj, held through the retiring cycle.
        tv.push_back(v_iss(2, 2, 3, 0, 0, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 8'h04));
        tv.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 2, 3, 8'h04));
        tv.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 8'h00));
        // WAW exception when the old write retires; no hold without issue.
        tv.push_back(v_iss(5, 1, 7, 0, 0, 0, 0, 8'h00));
        tv.push_back(v_iss(5, 2, 8, 0, 1, 5, 7, 8'h20));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 8'h20));
        tv.push_back(v_idle(1, 5, 8, 8'h20));
        tv.push_back(v_idle(0, 0, 0, 8'h00));
        // Maximum delay.
        tv.push_back(v_iss(7, 15, 15, 0, 0, 0, 0, 8'h00));
        for (int i = 1; i < 15; i++) tv.push_back(v_idle(0, 0, 0, 8'h80));
        tv.push_back(v_idle(1, 7, 15, 8'h80));
        tv.push_back(v_idle(0, 0, 0, 8'h00));

        // Reset state, with an issue request present.
        rst_n = 1'b0;
`ifdef A_SCHED_FLUSH_EN
        bus.i_flush = 1'b0;
`endif
        drive(mk(1, 1, 3, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        #12;
        check("rst_hold",    0, 32'(bus.o_hold),    32'd0);
        check("rst_wr_en",   0, 32'(bus.o_wr_en),   32'd0);
        check("rst_wr_addr", 0, 32'(bus.o_wr_addr), 32'd0);
        check("rst_wr_src",  0, 32'(bus.o_wr_src),  32'd0);
        check("rst_busy",    0, 32'(bus.o_busy),    32'd0);
        drive(v_idle(0, 0, 0, 8'h00));
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #2;
            check("hold",  i, 32'(bus.o_hold),  32'(tv[i].h));
            check("wr_en", i, 32'(bus.o_wr_en), 32'(tv[i].we));
            if (tv[i].we) begin
                check("wr_bus", i, 32'({bus.o_wr_addr, bus.o_wr_src}), 32'({tv[i].wa, tv[i].ws}));
            end
            check("busy", i, 32'(bus.o_busy), 32'(tv[i].bz));
        end

        // Reset asserted mid-flight discards the delay-15 reservation.
        @(negedge clk);
        drive(v_iss(4, 15, 3, 0, 0, 0, 0, 8'h00));
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            drive(v_idle(0, 0, 0, 8'h00));
            #2;
            check("pre_rst_busy", c, 32'(bus.o_busy), 32'h10);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 4, 32'(bus.o_busy),  32'd0);
        check("mid_rst_wr",   4, 32'(bus.o_wr_en), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 5; c <= 20; c++) begin
            @(negedge clk);
            #2;
            check("post_rst_wr",   c, 32'(bus.o_wr_en), 32'd0);
            check("post_rst_busy", c, 32'(bus.o_busy),  32'd0);
        end

`ifdef A_SCHED_FLUSH_EN
        // Flush with three writes pending.
        @(negedge clk);
        drive(v_iss(1, 6, 1, 0, 0, 0, 0, 8'h00));
        @(negedge clk);
        drive(v_iss(2, 6, 2, 0, 0, 0, 0, 8'h00));
        @(negedge clk);
        drive(v_iss(3, 6, 3, 0, 0, 0, 0, 8'h00));
        #2;
        check("fl_pre_busy", 2, 32'(bus.o_busy), 32'h06);
        @(negedge clk);
        drive(v_iss(4, 2, 4, 0, 0, 0, 0, 8'h00));
        bus.i_flush = 1'b1;
        #2;
        check("fl_hold",  3, 32'(bus.o_hold),  32'd1);
        check("fl_wr_en", 3, 32'(bus.o_wr_en), 32'd0);
        check("fl_busy",  3, 32'(bus.o_busy),  32'h0e);
        @(negedge clk);
        bus.i_flush = 1'b0;
        drive(v_idle(0, 0, 0, 8'h00));
        for (int c = 4; c <= 12; c++) begin
            #2;
            check("post_fl_wr",   c, 32'(bus.o_wr_en), 32'd0);
            check("post_fl_busy", c, 32'(bus.o_busy),  32'd0);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
